// File: rtl/mci_dmi_indirect_win.sv
// DMI indirect-access engine: NUM_WIN independent ADDR/DATA windows, each
// with a one-word read-prefetch buffer, optional address auto-increment and
// posted writes, plus a shared STATUS register (BUSY / sticky W1C ERR).

// One window: request FSM, address/data/buffer registers, sticky error bit.
module mci_dmi_indirect_win_lane #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_b,
    input  logic              addr_wr,
    input  logic              data_wr,
    input  logic              data_rd,
    input  logic              err_clr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              gnt,
    input  logic              rvalid,
    input  logic [DATA_W-1:0] rdata,
    output logic              req,
    output logic              we,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              auto_inc,
    output logic              busy,
    output logic              buf_valid,
    output logic              err,
    output logic [DATA_W-1:0] rbuf
);
    typedef enum logic [1:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ} state_t;

    state_t state, state_nx;
    logic   inc, cap_rd, err_set;

    assign busy = (state != IDLE);

    // Accesses that hit a busy window, or read an empty buffer, are dropped and flagged.
    assign err_set = (busy & (addr_wr | data_wr)) | (data_rd & ~buf_valid);

    // State register.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) state <= IDLE;
        else        state <= state_nx;
    end

    // Next state and memory-port outputs; every write is followed by a buffer refresh.
    always_comb begin
        state_nx = state;
        req      = 1'b0;
        we       = 1'b0;
        inc      = 1'b0;
        cap_rd   = 1'b0;
        case (state)
            IDLE: begin
                if (addr_wr)                    state_nx = RD_REQ;
                else if (data_wr)               state_nx = WR_REQ;
                else if (data_rd && buf_valid) begin
                    inc      = 1'b1;
                    state_nx = RD_REQ;
                end
            end
            RD_REQ: begin
                req = 1'b1;
                if (gnt) state_nx = RD_WAIT;
            end
            RD_WAIT: begin
                if (rvalid) begin
                    cap_rd   = 1'b1;
                    state_nx = IDLE;
                end
            end
            WR_REQ: begin
                req = 1'b1;
                we  = 1'b1;
                if (gnt) begin
                    inc      = 1'b1;
                    state_nx = RD_REQ;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Window registers; an error set in the same cycle as its W1C clear wins.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            addr      <= '0;
            auto_inc  <= 1'b0;
            mem_wdata <= '0;
            rbuf      <= '0;
            buf_valid <= 1'b0;
            err       <= 1'b0;
        end else begin
            if (addr_wr && !busy) begin
                addr     <= wdata[ADDR_W-1:0];
                auto_inc <= wdata[DATA_W-1];
            end else if (inc) begin
                addr <= addr + ADDR_W'(auto_inc);
            end
            if (data_wr && !busy) mem_wdata <= wdata;
            if (cap_rd)           rbuf <= rdata;
            if (cap_rd)
                buf_valid <= 1'b1;
            else if (!busy && (addr_wr || data_wr || data_rd))
                buf_valid <= 1'b0;
            err <= (err & ~err_clr) | err_set;
        end
    end
endmodule

module mci_dmi_indirect_win #(
    parameter int         NUM_WIN  = 2,
    parameter logic [6:0] DMI_BASE = 7'h58,
    parameter int         ADDR_W   = 16,
    parameter int         DATA_W   = 32
) (
    input  logic                        clk,
    input  logic                        rst_b,
    input  logic                        dmi_reg_en,
    input  logic                        dmi_reg_wr_en,
    input  logic [6:0]                  dmi_reg_addr,
    input  logic [DATA_W-1:0]           dmi_reg_wdata,
    output logic [DATA_W-1:0]           dmi_reg_rdata,
    output logic [NUM_WIN-1:0]          win_req,
    output logic [NUM_WIN-1:0]          win_we,
    output logic [NUM_WIN*ADDR_W-1:0]   win_addr,
    output logic [NUM_WIN*DATA_W-1:0]   win_wdata,
    input  logic [NUM_WIN-1:0]          win_gnt,
    input  logic [NUM_WIN-1:0]          win_rvalid,
    input  logic [NUM_WIN*DATA_W-1:0]   win_rdata
);
    logic                             rd, wr, hit_s;
    logic [NUM_WIN-1:0]               hit_a, hit_d, busy, auto_inc, buf_valid, err;
    logic [NUM_WIN-1:0][ADDR_W-1:0]   addr;
    logic [NUM_WIN-1:0][DATA_W-1:0]   rbuf;
    logic [DATA_W-1:0]                rd_val;

    assign rd    = dmi_reg_en & ~dmi_reg_wr_en;
    assign wr    = dmi_reg_en &  dmi_reg_wr_en;
    assign hit_s = (dmi_reg_addr == 7'(DMI_BASE + 2*NUM_WIN));

    for (genvar g = 0; g < NUM_WIN; g++) begin : g_win
        assign hit_a[g] = (dmi_reg_addr == 7'(DMI_BASE + 2*g));
        assign hit_d[g] = (dmi_reg_addr == 7'(DMI_BASE + 2*g + 1));
        assign win_addr[g*ADDR_W +: ADDR_W] = addr[g];

        mci_dmi_indirect_win_lane #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_lane (
            .clk       (clk),
            .rst_b     (rst_b),
            .addr_wr   (wr & hit_a[g]),
            .data_wr   (wr & hit_d[g]),
            .data_rd   (rd & hit_d[g]),
            .err_clr   (wr & hit_s & dmi_reg_wdata[8+g]),
            .wdata     (dmi_reg_wdata),
            .gnt       (win_gnt[g]),
            .rvalid    (win_rvalid[g]),
            .rdata     (win_rdata[g*DATA_W +: DATA_W]),
            .req       (win_req[g]),
            .we        (win_we[g]),
            .addr      (addr[g]),
            .mem_wdata (win_wdata[g*DATA_W +: DATA_W]),
            .auto_inc  (auto_inc[g]),
            .busy      (busy[g]),
            .buf_valid (buf_valid[g]),
            .err       (err[g]),
            .rbuf      (rbuf[g])
        );
    end

    // Read-data mux; unmapped addresses and empty buffers read as zero.
    always_comb begin
        rd_val = '0;
        for (int i = 0; i < NUM_WIN; i++) begin
            if (hit_s) begin
                rd_val[i]   = busy[i];
                rd_val[8+i] = err[i];
            end
            if (hit_a[i]) begin
                rd_val[ADDR_W-1:0] = addr[i];
                rd_val[DATA_W-1]   = auto_inc[i];
            end
            if (hit_d[i] && buf_valid[i]) rd_val = rbuf[i];
        end
    end

    // Registered read data, held until the next read.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b)  dmi_reg_rdata <= '0;
        else if (rd) dmi_reg_rdata <= rd_val;
    end
endmodule

// File: tb/tb_mci_dmi_indirect_win.sv
// Bench for mci_dmi_indirect_win: behavioural memory responder per window and a
// word-level reference model of the window registers, directed then random.
module tb_mci_dmi_indirect_win;
    localparam int         NW   = 2;
    localparam int         AW   = 16;
    localparam logic [6:0] BASE = 7'h58;
    localparam logic [6:0] STAT = 7'h5C;

    logic              clk, rst_b;
    logic              dmi_reg_en, dmi_reg_wr_en;
    logic [6:0]        dmi_reg_addr;
    logic [31:0]       dmi_reg_wdata, dmi_reg_rdata;
    logic [NW-1:0]     win_req, win_we, win_gnt, win_rvalid;
    logic [NW*AW-1:0]  win_addr;
    logic [NW*32-1:0]  win_wdata, win_rdata;

    mci_dmi_indirect_win #(.NUM_WIN(NW), .DMI_BASE(BASE), .ADDR_W(AW), .DATA_W(32)) dut (
        .clk(clk), .rst_b(rst_b),
        .dmi_reg_en(dmi_reg_en), .dmi_reg_wr_en(dmi_reg_wr_en),
        .dmi_reg_addr(dmi_reg_addr), .dmi_reg_wdata(dmi_reg_wdata),
        .dmi_reg_rdata(dmi_reg_rdata),
        .win_req(win_req), .win_we(win_we), .win_addr(win_addr), .win_wdata(win_wdata),
        .win_gnt(win_gnt), .win_rvalid(win_rvalid), .win_rdata(win_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0, n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // ---------------- environment memory (responder-owned writes) ----------
    function automatic logic [31:0] pat(input int w, input int a);
        return {4'(w + 1), 12'hC3A, 16'(a)};
    endfunction

    logic [31:0] pre_mem [int];   // directed preloads, written by the stimulus
    logic [31:0] wr_mem  [int];   // words the DUT wrote, written by the responder
    int  gnt_dly [NW];
    int  rv_dly  [NW];
    bit  hold    [NW];
    bit  rnd;

    int          ph [NW];
    int          cnt[NW];
    logic [15:0] raddr[NW];

    // Memory responder: grant after a delay, then return read data after another.
    initial begin
        win_gnt = '0; win_rvalid = '0; win_rdata = '0;
        for (int w = 0; w < NW; w++) begin ph[w] = 0; cnt[w] = 0; raddr[w] = '0; end
        forever begin
            @(posedge clk); #1;
            win_gnt = '0; win_rvalid = '0;
            for (int w = 0; w < NW; w++) begin
                if (ph[w] == 0 && win_req[w] === 1'b1 && !hold[w]) begin
                    ph[w]  = 1;
                    cnt[w] = rnd ? int'($urandom_range(0, 3)) : gnt_dly[w];
                end
                if (ph[w] == 1) begin
                    if (win_req[w] !== 1'b1) ph[w] = 0;
                    else if (cnt[w] == 0) begin
                        win_gnt[w] = 1'b1;
                        if (win_we[w]) begin
                            wr_mem[w*65536 + int'(win_addr[w*AW +: AW])] = win_wdata[w*32 +: 32];
                            ph[w] = 0;
                        end else begin
                            raddr[w] = win_addr[w*AW +: AW];
                            ph[w]    = 2;
                            cnt[w]   = rnd ? int'($urandom_range(0, 3)) : rv_dly[w];
                        end
                    end else cnt[w]--;
                end else if (ph[w] == 2) begin
                    if (cnt[w] == 0) begin
                        win_rvalid[w] = 1'b1;
                        if (wr_mem.exists(w*65536 + int'(raddr[w])))
                            win_rdata[w*32 +: 32] = wr_mem[w*65536 + int'(raddr[w])];
                        else if (pre_mem.exists(w*65536 + int'(raddr[w])))
                            win_rdata[w*32 +: 32] = pre_mem[w*65536 + int'(raddr[w])];
                        else
                            win_rdata[w*32 +: 32] = pat(w, int'(raddr[w]));
                        ph[w] = 0;
                    end else cnt[w]--;
                end
            end
        end
    end

    // ---------------- reference model (word-level register behaviour) -------
    logic [31:0] ref_mem [int];
    int          m_addr [NW];
    bit          m_inc  [NW];
    bit          m_bv   [NW];
    bit          m_err  [NW];
    logic [31:0] m_buf  [NW];

    function automatic logic [31:0] ref_rd(input int w, input int a);
        if (ref_mem.exists(w*65536 + a)) return ref_mem[w*65536 + a];
        return pat(w, a);
    endfunction

    function automatic void m_reset();
        for (int w = 0; w < NW; w++) begin
            m_addr[w] = 0; m_inc[w] = 0; m_bv[w] = 0; m_err[w] = 0; m_buf[w] = '0;
        end
    endfunction

    function automatic void m_prefetch(input int w);
        m_buf[w] = ref_rd(w, m_addr[w]);
        m_bv[w]  = 1'b1;
    endfunction

    function automatic void m_advance(input int w);
        m_addr[w] = (m_addr[w] + (m_inc[w] ? 1 : 0)) % 65536;
    endfunction

    function automatic void m_addr_wr(input int w, input logic [31:0] v);
        m_addr[w] = int'(v[15:0]);
        m_inc[w]  = v[31];
        m_prefetch(w);
    endfunction

    function automatic void m_data_wr(input int w, input logic [31:0] v);
        ref_mem[w*65536 + m_addr[w]] = v;
        m_advance(w);
        m_prefetch(w);
    endfunction

    function automatic logic [31:0] m_data_rd(input int w);
        logic [31:0] r;
        if (!m_bv[w]) begin
            m_err[w] = 1'b1;
            return 32'h0;
        end
        r = m_buf[w];
        m_advance(w);
        m_prefetch(w);
        return r;
    endfunction

    task automatic set_mem(input int w, input int a, input logic [31:0] v);
        pre_mem[w*65536 + a] = v;
        ref_mem[w*65536 + a] = v;
    endtask

    // ---------------- DMI access tasks -------------------------------------
    function automatic logic [6:0] a_reg(input int w);
        return BASE + 7'(2*w);
    endfunction

    function automatic logic [6:0] d_reg(input int w);
        return BASE + 7'(2*w + 1);
    endfunction

    task automatic dmi_wr(input logic [6:0] a, input logic [31:0] d);
        @(negedge clk);
        dmi_reg_en = 1'b1; dmi_reg_wr_en = 1'b1; dmi_reg_addr = a; dmi_reg_wdata = d;
        @(negedge clk);
        dmi_reg_en = 1'b0; dmi_reg_wr_en = 1'b0;
    endtask

    task automatic dmi_rd(input logic [6:0] a, output logic [31:0] d);
        @(negedge clk);
        dmi_reg_en = 1'b1; dmi_reg_wr_en = 1'b0; dmi_reg_addr = a;
        @(negedge clk);
        dmi_reg_en = 1'b0;
        d = dmi_reg_rdata;
    endtask

    task automatic wait_idle();
        logic [31:0] s;
        int n;
        n = 0;
        dmi_rd(STAT, s);
        while (s[7:0] != 8'h0 && n < 200) begin
            dmi_rd(STAT, s);
            n++;
        end
        if (s[7:0] != 8'h0) chk("idle_timeout", {24'h0, s[7:0]}, 32'h0);
    endtask

    task automatic op_addr_wr(input int w, input logic [31:0] v);
        dmi_wr(a_reg(w), v);
        m_addr_wr(w, v);
    endtask

    task automatic op_data_wr(input int w, input logic [31:0] v);
        dmi_wr(d_reg(w), v);
        m_data_wr(w, v);
    endtask

    task automatic op_data_rd(input int w, input string tag);
        logic [31:0] got, exp;
        dmi_rd(d_reg(w), got);
        exp = m_data_rd(w);
        chk(tag, got, exp);
    endtask

    task automatic op_addr_rd(input int w, input string tag);
        logic [31:0] got, exp;
        dmi_rd(a_reg(w), got);
        exp = {m_inc[w], 15'h0, 16'(m_addr[w])};
        chk(tag, got, exp);
    endtask

    task automatic chk_status(input string tag, input logic [7:0] busy_exp);
        logic [31:0] got, exp;
        dmi_rd(STAT, got);
        exp = {24'h0, busy_exp};
        for (int w = 0; w < NW; w++) exp[8+w] = m_err[w];
        chk(tag, got, exp);
    endtask

    // ---------------- stimulus ---------------------------------------------
    initial begin
        logic [31:0] v;
        int w, op;
        dmi_reg_en = 1'b0; dmi_reg_wr_en = 1'b0; dmi_reg_addr = '0; dmi_reg_wdata = '0;
        rnd = 1'b0;
        for (int i = 0; i < NW; i++) begin gnt_dly[i] = 0; rv_dly[i] = 0; hold[i] = 1'b0; end
        m_reset();
        rst_b = 1'b1;
        #2 rst_b = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_rdata", dmi_reg_rdata, 32'h0);
        chk("rst_req", {30'h0, win_req}, 32'h0);
        chk("rst_we", {30'h0, win_we}, 32'h0);
        rst_b = 1'b1;
        chk_status("rst_status", 8'h0);
        op_addr_rd(0, "rst_addr0");

        // Unmapped addresses read zero and ignore writes.
        dmi_wr(7'h5D, 32'hFFFF_FFFF);
        dmi_rd(7'h5D, v); chk("unmapped_5d", v, 32'h0);
        dmi_rd(7'h57, v); chk("unmapped_57", v, 32'h0);
        chk_status("unmapped_status", 8'h0);

        // Auto-increment prefetch, grant after 2 cycles, rvalid 1 cycle later.
        gnt_dly[0] = 2; rv_dly[0] = 0;
        set_mem(0, 16'h10, 32'hA5A5_0001);
        set_mem(0, 16'h11, 32'hA5A5_0002);
        op_addr_wr(0, 32'h8000_0010);
        wait_idle();
        op_data_rd(0, "t1_rd0");
        wait_idle();
        chk_status("t1_status", 8'h0);
        op_data_rd(0, "t1_rd1");
        wait_idle();
        op_addr_rd(0, "t1_addr");

        // Posted write without increment; port held stable until grant.
        op_addr_wr(0, 32'h0000_0020);
        wait_idle();
        op_data_wr(0, 32'hDEAD_BEEF);
        chk("t2_req", {31'h0, win_req[0]}, 32'h1);
        chk("t2_we", {31'h0, win_we[0]}, 32'h1);
        chk("t2_addr", {16'h0, win_addr[AW-1:0]}, 32'h20);
        chk("t2_wdata", win_wdata[31:0], 32'hDEAD_BEEF);
        @(negedge clk);
        chk("t2_wdata_hold", win_wdata[31:0], 32'hDEAD_BEEF);
        chk("t2_we_hold", {31'h0, win_we[0]}, 32'h1);
        wait_idle();
        op_data_rd(0, "t2_rd");
        wait_idle();
        op_addr_rd(0, "t2_addr_rd");

        // Address wrap at the top of the window.
        op_addr_wr(0, 32'h8000_FFFF);
        wait_idle();
        op_data_rd(0, "t3_rd_ffff");
        wait_idle();
        op_addr_rd(0, "t3_wrap_addr");
        op_data_rd(0, "t3_rd_0000");
        wait_idle();

        // Read of a busy window: returns 0, sets ERR; W1C clears it.
        hold[1] = 1'b1;
        op_addr_wr(1, 32'h8000_0300);
        repeat (3) @(negedge clk);
        dmi_rd(d_reg(1), v);
        chk("t4_busy_rd", v, 32'h0);
        m_err[1] = 1'b1;
        chk_status("t4_status_err", 8'h02);
        dmi_wr(STAT, 32'h0000_0200);
        m_err[1] = 1'b0;
        chk_status("t4_status_clr", 8'h02);
        hold[1] = 1'b0;
        wait_idle();
        chk_status("t4_status_idle", 8'h0);
        op_data_rd(1, "t4_rd");
        wait_idle();

        // Both windows prefetching concurrently at the same word address.
        gnt_dly[0] = 3; rv_dly[0] = 0; gnt_dly[1] = 1; rv_dly[1] = 2;
        set_mem(0, 16'h40, 32'h1111_0040); set_mem(0, 16'h41, 32'h1111_0041);
        set_mem(1, 16'h40, 32'h2222_0040); set_mem(1, 16'h41, 32'h2222_0041);
        op_addr_wr(0, 32'h8000_0040);
        op_addr_wr(1, 32'h8000_0040);
        wait_idle();
        op_data_rd(1, "t5_w1_a");
        op_data_rd(0, "t5_w0_a");
        wait_idle();
        op_data_rd(0, "t5_w0_b");
        op_data_rd(1, "t5_w1_b");
        wait_idle();
        chk_status("t5_status", 8'h0);

        // Reset while window 0 waits for rvalid; the late rvalid is ignored.
        gnt_dly[0] = 0; rv_dly[0] = 8;
        op_addr_wr(0, 32'h8000_0100);
        op_addr_rd(0, "t6_addr_pre");
        rst_b = 1'b0;
        #1;
        chk("t6_req", {30'h0, win_req}, 32'h0);
        chk("t6_rdata", dmi_reg_rdata, 32'h0);
        repeat (2) @(negedge clk);
        rst_b = 1'b1;
        m_reset();
        repeat (12) @(negedge clk);
        chk("t6_req_after", {30'h0, win_req}, 32'h0);
        op_data_rd(0, "t6_rd_empty");
        chk_status("t6_status", 8'h0);
        rv_dly[0] = 0;

        // Random operations against the reference model.
        rnd = 1'b1;
        dmi_wr(STAT, 32'h0000_0300);
        for (int i = 0; i < NW; i++) m_err[i] = 1'b0;
        op_addr_wr(0, $urandom);
        op_addr_wr(1, $urandom);
        wait_idle();
        for (int k = 0; k < 200; k++) begin
            w  = int'($urandom_range(0, NW - 1));
            op = int'($urandom_range(0, 3));
            case (op)
                0: begin
                    v = $urandom;
                    if ($urandom_range(0, 3) == 0) v[15:0] = 16'hFFFE + 16'($urandom_range(0, 1));
                    op_addr_wr(w, v);
                end
                1: op_data_wr(w, $urandom);
                2: op_data_rd(w, "rnd_data");
                default: op_addr_rd(w, "rnd_addr");
            endcase
            wait_idle();
            if (k % 8 == 0) chk_status("rnd_status", 8'h0);
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/mci_dmi_indirect_win.md
Name: mci_dmi_indirect_win

Overview:
- Parametrised DMI indirect-access engine for the MCI uncore DMI space.
- Generalises the single fixed ADDR/DATA window pair into NUM_WIN independent windows. Each window has:
  - a read-prefetch buffer,
  - optional address auto-increment,
  - posted writes,
  - a shared STATUS register with sticky error bits.
- Sits between the uncore DMI register decode and per-window SRAM/trace-memory request ports.

Parameters:
- NUM_WIN, 2, number of indirect windows (1..8).
- DMI_BASE, 7'h58, DMI address of window 0 ADDR register.
- ADDR_W, 16, word-address width of each window's target memory.
- DATA_W, 32, data width (fixed 32 for DMI; any other value is illegal).

Ports:
- clk  in  1  clock.
- rst_b  in  1  async active-low reset.
- dmi_reg_en  in  1  DMI uncore access strobe, one cycle per access.
- dmi_reg_wr_en  in  1  1=write, 0=read; valid with dmi_reg_en.
- dmi_reg_addr  in  7  DMI register address.
- dmi_reg_wdata  in  32  DMI write data.
- dmi_reg_rdata  out  32  registered DMI read data.
- win_req  out  NUM_WIN  per-window memory request, held until grant.
- win_we  out  NUM_WIN  per-window write enable, stable while req.
- win_addr  out  NUM_WIN*ADDR_W  per-window word address, stable while req.
- win_wdata  out  NUM_WIN*32  per-window write data, stable while req.
- win_gnt  in  NUM_WIN  request accepted this cycle.
- win_rvalid  in  NUM_WIN  read data valid, any cycle after the read grant.
- win_rdata  in  NUM_WIN*32  per-window read data.

Behaviour:
- Address map:
  - Window i ADDR register at DMI_BASE+2i; DATA register at DMI_BASE+2i+1.
  - STATUS register at DMI_BASE+2*NUM_WIN.
  - Other addresses: read 0, writes ignored.
- ADDR register fields: [ADDR_W-1:0] word address, [31] AUTO_INC; other bits read 0.
- STATUS register fields: bit i = BUSY_i (RO); bit 8+i = ERR_i (sticky, W1C).
- Read latency:
  - dmi_reg_rdata updates on the clock edge after dmi_reg_en & !dmi_reg_wr_en and holds until the next read.
  - Reset value 0.
- Per-window FSM states: IDLE, RD_REQ, RD_WAIT, WR_REQ. BUSY = state != IDLE.
- RD_REQ:
  - Drives win_req=1, win_we=0.
  - On win_gnt, goes to RD_WAIT.
- RD_WAIT:
  - On win_rvalid, captures rdata into buf, sets buf_valid=1, goes to IDLE.
- WR_REQ:
  - Drives win_req=1, win_we=1.
  - On win_gnt, addr <= addr+AUTO_INC, then goes to RD_REQ (buffer refresh).
- ADDR write in IDLE: load addr and AUTO_INC, clear buf_valid, go to RD_REQ.
- ADDR write while BUSY: dropped, ERR_i set.
- DATA read with buf_valid:
  - Returns buf, clears buf_valid.
  - addr <= addr+AUTO_INC, then goes to RD_REQ (prefetch of the next or same word).
- DATA read without buf_valid (BUSY): returns 0, ERR_i set, no state change.
- DATA write in IDLE: capture wdata, clear buf_valid, go to WR_REQ.
- DATA write while BUSY: dropped, ERR_i set.
- ADDR read: returns {AUTO_INC, zeros, addr}; no side effect.
- Address increment wraps modulo 2^ADDR_W; 0xFFFF+1 -> 0x0000 for ADDR_W=16.
- At most one outstanding request per window; windows are fully independent and may be active concurrently.
- win_gnt in the same cycle as a new DMI access to that window: the FSM transition takes priority. The DMI access sees BUSY as registered before that edge.
- STATUS write: each 1 in bits [8+NUM_WIN-1:8] clears the corresponding ERR. If an error event and a W1C hit the same bit in the same cycle, the set wins.
- Reset (async, any state):
  - All FSMs to IDLE; win_req/win_we=0.
  - addr, wdata, buf, AUTO_INC, buf_valid, ERR, dmi_reg_rdata = 0.
  - An in-flight rvalid after reset release is ignored.

Test Plan:
- Write ADDR0=0x8000_0010; memory[0x10]=0xA5A5_0001, memory[0x11]=0xA5A5_0002; grant after 2 cycles, rvalid 1 cycle later -> read DATA0 twice (polling STATUS BUSY0=0 between) returns 0xA5A5_0001 then 0xA5A5_0002; ADDR0 reads 0x8000_0012.
- ADDR0=0x0000_0020 (no inc); write DATA0=0xDEAD_BEEF -> win_we=1, addr 0x20, wdata held until gnt; subsequent DATA0 read returns 0xDEAD_BEEF, addr stays 0x20.
- ADDR0=0x8000_FFFF; read DATA0 -> next prefetch at 0x0000 (wrap); ADDR0 reads 0x8000_0000.
- Hold win_gnt[1]=0 after ADDR1 write; read DATA1 -> returns 0, STATUS=0x0000_0202; write STATUS=0x200 -> ERR1 cleared; release gnt -> BUSY1 clears.
- Window 0 and window 1 prefetching simultaneously with interleaved grants -> each returns its own data; no cross-window corruption.
- Assert rst_b low while window 0 in RD_WAIT -> win_req=0, STATUS=0, dmi_reg_rdata=0 immediately; late rvalid after release does not set buf_valid (DATA0 read returns 0, ERR0=1).
